// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use, taken-branch and multi-cycle EX stall/flush control for the 5-stage core.
// Define HAZARD_CTRL_STATS_EN to add the stall_count/flush_count statistics outputs.
module hazard_ctrl #(
  parameter int REG_AW    = 5,
  parameter int MC_CYCLES = 4,
  parameter int CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_mem_read,
  input  logic              ex_br_taken,
  input  logic              ex_mc_start,
  output logic              stall_if,
  output logic              stall_cs,
  output logic              flush_if,
  output logic              flush_id,
  output logic              ex_hold,
  output logic              mc_done,
  output logic              busy
`ifdef HAZARD_CTRL_STATS_EN
  ,
  output logic [31:0]       stall_count,
  output logic [31:0]       flush_count
`endif
);
  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] MC_BUSY = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_busy, cnt_zero, raw_lu, start, lu;

  assign in_busy  = state_q == MC_BUSY;
  assign cnt_zero = cnt_q == '0;
  assign raw_lu   = ex_mem_read & (|ex_rd) &
                    ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
  // Priority below reset: branch squash, then multi-cycle start, then load-use.
  assign start    = !in_busy & !ex_br_taken & ex_mc_start;
  assign lu       = !in_busy & !ex_br_taken & !ex_mc_start & raw_lu;

  assign stall_if = !rst & (in_busy | start | lu);
  assign stall_cs = stall_if;
  assign flush_if = rst | (!in_busy & ex_br_taken);
  assign flush_id = rst | (!in_busy & (ex_br_taken | lu));
  assign ex_hold  = !rst & (in_busy | start);
  assign busy     = !rst & in_busy;
  assign mc_done  = !rst & in_busy & cnt_zero;

  always_comb begin
    state_d = start ? MC_BUSY : (in_busy & cnt_zero) ? IDLE : state_q;
    cnt_d   = start ? CNT_W'(MC_CYCLES - 2) : (in_busy & !cnt_zero) ? cnt_q - CNT_W'(1) : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZARD_CTRL_STATS_EN
  logic [31:0] stall_count_q, flush_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_q + {31'b0, stall_cs};
      flush_count_q <= flush_count_q + {31'b0, flush_if};
    end
  end

  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: table-driven directed check of hazard_ctrl with MC_CYCLES=4.
module tb_hazard_ctrl;
  typedef struct {
    logic       rst;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       mr;
    logic       br;
    logic       mc;
    logic [6:0] exp;
    string      name;
  } vec_t;

  // exp bit order: stall_if stall_cs flush_if flush_id ex_hold mc_done busy
  localparam logic [6:0] NO = 7'b0000000;
  localparam logic [6:0] LU = 7'b1101000;
  localparam logic [6:0] FL = 7'b0011000;
  localparam logic [6:0] ST = 7'b1100100;
  localparam logic [6:0] BZ = 7'b1100101;
  localparam logic [6:0] DN = 7'b1100111;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, id_use_rs1, id_use_rs2, ex_mem_read, ex_br_taken, ex_mc_start;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       stall_if, stall_cs, flush_if, flush_id, ex_hold, mc_done, busy;
  int         n_cmp = 0;
  int         n_bad = 0;
`ifdef HAZARD_CTRL_STATS_EN
  logic [31:0] stall_count, flush_count;
`endif

  hazard_ctrl #(.REG_AW(5), .MC_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_br_taken(ex_br_taken), .ex_mc_start(ex_mc_start),
    .stall_if(stall_if), .stall_cs(stall_cs), .flush_if(flush_if), .flush_id(flush_id),
    .ex_hold(ex_hold), .mc_done(mc_done), .busy(busy)
`ifdef HAZARD_CTRL_STATS_EN
    , .stall_count(stall_count), .flush_count(flush_count)
`endif
  );

  function automatic vec_t mk(input logic r, input logic [4:0] s1, input logic [4:0] s2,
                              input logic a1, input logic a2, input logic [4:0] d,
                              input logic m, input logic b, input logic c,
                              input logic [6:0] e, input string nm);
    vec_t t;
    t.rst = r; t.rs1 = s1; t.rs2 = s2; t.u1 = a1; t.u2 = a2; t.rd = d;
    t.mr = m; t.br = b; t.mc = c; t.exp = e; t.name = nm;
    return t;
  endfunction

  task automatic apply(input vec_t t);
    logic [6:0] got;
    @(posedge clk);
    #1;
    rst = t.rst; id_rs1 = t.rs1; id_rs2 = t.rs2; id_use_rs1 = t.u1; id_use_rs2 = t.u2;
    ex_rd = t.rd; ex_mem_read = t.mr; ex_br_taken = t.br; ex_mc_start = t.mc;
    #3;
    got = {stall_if, stall_cs, flush_if, flush_id, ex_hold, mc_done, busy};
    n_cmp++;
    if (got !== t.exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", t.name, got, t.exp);
    end
  endtask

  vec_t v[25];

  initial begin
    rst = 1'b1; id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_rd = '0; ex_mem_read = 0; ex_br_taken = 0; ex_mc_start = 0;
    v[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, FL, "reset");
    v[1]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, FL, "reset_with_mc");
    v[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, NO, "idle");
    v[3]  = mk(0, 5, 0, 1, 0, 5, 1, 0, 0, LU, "lu_rs1");
    v[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, NO, "lu_next");
    v[5]  = mk(0, 0, 0, 1, 1, 0, 1, 0, 0, NO, "rd_zero");
    v[6]  = mk(0, 1, 7, 1, 1, 7, 1, 0, 0, LU, "lu_rs2");
    v[7]  = mk(0, 9, 0, 0, 1, 9, 1, 0, 0, NO, "lu_rs1_unused");
    v[8]  = mk(0, 9, 0, 1, 0, 9, 0, 0, 0, NO, "no_load");
    v[9]  = mk(0, 5, 0, 1, 0, 5, 1, 1, 0, FL, "br_over_lu");
    v[10] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, FL, "br_over_mc");
    v[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, NO, "br_no_mc_state");
    v[12] = mk(0, 5, 0, 1, 0, 5, 1, 0, 1, ST, "mc_start_T");
    v[13] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, BZ, "mc_T1_ignore");
    v[14] = mk(0, 5, 0, 1, 0, 5, 1, 0, 0, BZ, "mc_T2");
    v[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, DN, "mc_T3_done");
    v[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, ST, "mc_b2b_start");
    v[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, BZ, "mc_b2b_T1");
    v[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, BZ, "mc_b2b_T2");
    v[19] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, DN, "mc_b2b_done");
    v[20] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, ST, "abort_start");
    v[21] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, BZ, "abort_T1");
    v[22] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, FL, "abort_rst");
    v[23] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, NO, "abort_after");
    v[24] = mk(0, 3, 3, 0, 1, 3, 1, 0, 0, LU, "after_abort_lu");
    for (int i = 0; i < 25; i++) apply(v[i]);
    // Statistics sequence: load-use, branch, one multi-cycle op
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, FL, "st_rst"));
    apply(mk(0, 5, 0, 1, 0, 5, 1, 0, 0, LU, "st_lu"));
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, NO, "st_lu_next"));
    apply(mk(0, 5, 0, 1, 0, 5, 1, 1, 0, FL, "st_br"));
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, ST, "st_mc"));
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, BZ, "st_mc1"));
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, BZ, "st_mc2"));
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, DN, "st_mc3"));
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, NO, "st_idle"));
`ifdef HAZARD_CTRL_STATS_EN
    n_cmp++;
    if (stall_count !== 32'd5) begin
      n_bad++;
      $display("FAIL stall_count: got %0d expected 5", stall_count);
    end
    n_cmp++;
    if (flush_count !== 32'd1) begin
      n_bad++;
      $display("FAIL flush_count: got %0d expected 1", flush_count);
    end
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
